// File: rtl/prio_encoder_rr.sv
// Single-register priority encoder with a valid/ready handshake on both sides.
// Selection is either fixed (bit 0 highest) or round-robin from a rotating pointer.
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_multi,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] sel;
  logic [W:0]   pos;
  logic         found;
  logic         multi;
  logic         accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign base     = (MODE == 1) ? ptr : '0;
  assign multi    = |(req & (req - N'(1)));

  // Scan N positions starting at base; the wrap keeps every index below N
  // even when N is not a power of two.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, base} + (W+1)'(k);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (!found && req[pos[W-1:0]]) begin
        found = 1'b1;
        sel   = pos[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_multi <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= sel;
      out_none  <= !found;
      out_multi <= multi;
      if (MODE == 1 && found) begin
        ptr <= (sel == W'(N-1)) ? '0 : sel + W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of request lines; legal values 2..64.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = fixed priority (bit 0 highest), 1 = round-robin priority.
REQ-003 SHALL derive W = ceil(log2(N)) internally, meaning index width; W is not overridable.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  N  request vector, sampled on input handshake.
REQ-008 SHALL have port in_valid  input  1  req is valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block can accept req this cycle.
REQ-010 SHALL have port out_idx  output  W  encoded index of the selected request bit.
REQ-011 SHALL have port out_none  output  1  sampled req was all-zero.
REQ-012 SHALL have port out_multi  output  1  sampled req had more than one bit set.
REQ-013 SHALL have port out_valid  output  1  out_idx/out_none/out_multi are valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the output this cycle.

Function
REQ-015 SHALL accept an input transfer on a clk edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
REQ-017 SHALL register out_idx, out_none, out_multi and set out_valid on the edge following acceptance; latency exactly 1 cycle.
REQ-018 SHALL complete an output transfer on an edge where out_valid && out_ready; with no new acceptance on that edge, out_valid SHALL clear.
REQ-019 SHALL hold out_idx, out_none, out_multi and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL accept a new input on the same edge as an output transfer, and SHALL update outputs with the new result (out_valid stays 1).
REQ-021 In MODE 0, out_idx SHALL be the lowest set bit index of req.
REQ-022 In MODE 1, out_idx SHALL be the first set bit at or above ptr, searching upward and wrapping from N-1 to 0.
REQ-023 SHALL hold ptr, a W-bit round-robin pointer, reset to 0; ptr SHALL update only on input acceptance in MODE 1 with req != 0, to (selected index + 1) mod N.
REQ-024 Wrap rule: selected index N-1 SHALL set ptr to 0, including when N is not a power of two.
REQ-025 An all-zero req SHALL produce out_none = 1, out_idx = 0, out_multi = 0, and SHALL leave ptr unchanged.
REQ-026 out_multi SHALL be 1 iff popcount(req) >= 2; out_idx SHALL still follow REQ-021/REQ-022.
REQ-027 In MODE 0, ptr SHALL remain 0 and SHALL have no effect.
REQ-028 req SHALL be ignored when in_valid is 0 or in_ready is 0.

Reset
REQ-029 On rst_n low, the block SHALL immediately, without waiting for clk, drive out_valid = 0, out_idx = 0, out_none = 0, out_multi = 0 and ptr = 0.
REQ-030 While rst_n is low, in_ready SHALL be 1.
REQ-031 Reset asserted mid-transfer SHALL discard any held output, with no output transfer completing.
REQ-032 The first acceptance after rst_n deasserts SHALL be on the first rising edge where rst_n is sampled high.

Verification
REQ-033 N=8, MODE 0, out_ready = 1, send req 8'b0000_0001, 8'b1000_0000 and 8'b0110_0100 on back-to-back cycles -> out_idx 0, 7, 2 on consecutive cycles; out_multi 0, 0, 1; out_valid continuous.
REQ-034 N=8, MODE 1, send 8'b1000_0001 four times -> out_idx 0, 7, 0, 7; ptr sequence 1, 0, 1, 0.
REQ-035 N=8, any MODE, send req 0 -> out_none = 1, out_idx = 0, out_multi = 0; in MODE 1 the next req 8'b0000_0010 with ptr = 1 -> out_idx 1.
REQ-036 Backpressure: out_ready = 0 for 3 cycles after the first result while in_valid is held -> in_ready = 0, outputs stable; out_ready = 1 -> the next result follows on the next edge, with no loss or duplication.
REQ-037 N=5, MODE 1, send req 5'b10000 then 5'b10001 -> out_idx 4, then 0 (ptr wrapped to 0).
REQ-038 Assert rst_n low between edges while out_valid = 1 -> out_valid drops to 0 immediately; ptr = 0 at the first post-reset acceptance.
